// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b011,
        OP_LHU = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } mem_op_t;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        DRAIN,
        RESP,
        ERR_RSP
    } lsu_state_t;

    function automatic logic [2:0] op_bytes(input mem_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of gathered load bytes; stores yield zero.
module lsu_extend
    import lsu_pkg::*;
(
    input  mem_op_t     i_op,
    input  logic [31:0] i_gather,
    output logic [31:0] o_rdata
);

    always_comb begin
        o_rdata = '0;
        case (i_op)
            OP_LB:   o_rdata = {{24{i_gather[7]}}, i_gather[7:0]};
            OP_LBU:  o_rdata = {24'd0, i_gather[7:0]};
            OP_LH:   o_rdata = {{16{i_gather[15]}}, i_gather[15:0]};
            OP_LHU:  o_rdata = {16'd0, i_gather[15:0]};
            OP_LW:   o_rdata = i_gather;
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequences load/store requests onto a byte-wide synchronous RAM, one byte per cycle,
// gathering load bytes and extending them for the response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    lsu_state_t    r_state;
    lsu_state_t    w_state_next;
    mem_op_t       r_op;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [2:0]    r_idx;

    logic [31:0]   w_gather;
    logic [31:0]   w_ext;
    logic [32:0]   w_end;
    logic [2:0]    w_n;
    logic          w_store;
    logic          w_accept;
    logic          w_range_err;
    logic          w_last;
    logic          w_cap_en;
    logic [1:0]    w_cap_idx;

    // Range check in 33 bits so addresses near 2^32 cannot wrap into range.
    assign w_accept    = (r_state == IDLE) && req_valid;
    assign w_end       = {1'b0, req_addr} + {30'd0, op_bytes(mem_op_t'(req_op))};
    assign w_range_err = w_end > 33'(DEPTH);
    assign w_n         = op_bytes(r_op);
    assign w_store     = op_is_store(r_op);
    assign w_last      = (r_idx == (w_n - 3'd1));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_next = w_range_err ? ERR_RSP : ACCESS;
            ACCESS:  if (w_last)    w_state_next = w_store ? RESP : DRAIN;
            DRAIN:   w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            ERR_RSP: if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (r_state)
            IDLE:    req_ready = 1'b1;
            // Strobes are gated by reset so an aborting reset edge commits no further byte.
            ACCESS: begin
                mem_we = w_store & rst_n;
                mem_re = ~w_store & rst_n;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = w_ext;
            end
            ERR_RSP: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= OP_LB;
            r_addr  <= '0;
            r_wdata <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_op    <= mem_op_t'(req_op);
            r_addr  <= req_addr[AW-1:0];
            r_wdata <= req_wdata;
            r_idx   <= '0;
        end else if (r_state == ACCESS) begin
            r_idx   <= r_idx + 3'd1;
        end
    end

    assign mem_addr  = r_addr + AW'(r_idx);
    assign mem_wdata = r_wdata[{r_idx[1:0], 3'b000} +: 8];

    // Read data lags the strobe by one cycle, so the lane written is the previous index.
    assign w_cap_en  = ~w_store && (((r_state == ACCESS) && (r_idx != 3'd0)) || (r_state == DRAIN));
    assign w_cap_idx = (r_state == DRAIN) ? 2'(w_n - 3'd1) : 2'(r_idx - 3'd1);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_byte;
            always_ff @(posedge clk) begin
                if (!rst_n || w_accept)                   r_byte <= '0;
                else if (w_cap_en && (w_cap_idx == gi))  r_byte <= mem_rdata;
            end
            assign w_gather[8*gi +: 8] = r_byte;
        end
    endgenerate

    lsu_extend u_extend (
        .i_op     (r_op),
        .i_gather (w_gather),
        .o_rdata  (w_ext)
    );

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: vector table through a scoreboard queue, plus stall and reset sequences.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    logic [7:0]    ram [DEPTH];
    logic          ram_clear;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwe;
        int          nre;
    } exp_t;

    exp_t sb[$];

    load_store_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int k = 0; k < DEPTH; k++) ram[k] <= 8'h00;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
        end
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // hold > 0 keeps rsp_ready low that many cycles and pulses a stray SB meanwhile.
    task automatic run_req(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        exp_t e;
        exp_t got;
        int   n;
        int   t;
        int   lat;
        int   nwe;
        int   nre;
        logic overlap;
        logic timed_out;
        logic [31:0] first_rdata;

        n = (op inside {OP_LB, OP_LBU, OP_SB}) ? 1 : (op inside {OP_LH, OP_LHU, OP_SH}) ? 2 : 4;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        if (exp_err) begin
            e.lat = 0; e.nwe = 0; e.nre = 0;
        end else if (op inside {OP_SB, OP_SH, OP_SW}) begin
            e.lat = n; e.nwe = n; e.nre = 0;
        end else begin
            e.lat = n + 1; e.nwe = 0; e.nre = n;
        end
        sb.push_back(e);

        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
        timed_out = 1'b0;
        t = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            t++;
            if (t > 20) begin timed_out = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; nwe = 0; nre = 0; overlap = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_we) nwe++;
            if (mem_re) nre++;
            if (mem_we && mem_re) overlap = 1'b1;
            if (rsp_valid || timed_out) break;
            @(posedge clk);
            lat++;
            if (lat > 20) begin timed_out = 1'b1; end
        end
        first_rdata = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h30; req_wdata = 32'h77;
            @(negedge clk);
            if (mem_we) nwe++;
            if (mem_re) nre++;
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rdata", rsp_rdata, first_rdata);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        got = sb.pop_front();
        if (timed_out) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: op=%s addr=0x%08h no response within bound", op.name(), addr);
        end else begin
            check("rdata", rsp_rdata, got.rdata);
            check("err", {31'd0, rsp_err}, {31'd0, got.err});
            check("latency", lat, got.lat);
            check("mem_we_count", nwe, got.nwe);
            check("mem_re_count", nre, got.nre);
            check("we_re_overlap", {31'd0, overlap}, 32'd0);
        end
        $display("txn op=%s addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0d lat=%0d",
                 op.name(), addr, wdata, rsp_rdata, rsp_err, lat);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("idle_after_rsp", {30'd0, req_ready, rsp_valid}, 32'd2);
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{OP_SW,  32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0},
            '{OP_LW,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0},
            '{OP_LB,  32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 1'b0},
            '{OP_LBU, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0},
            '{OP_LH,  32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 1'b0},
            '{OP_LHU, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 1'b0},
            '{OP_LW,  32'h0000_0011, 32'h0,         32'h00DE_ADBE, 1'b0},
            '{OP_SH,  32'h0000_0021, 32'h0000_1234, 32'h0000_0000, 1'b0},
            '{OP_LW,  32'h0000_0020, 32'h0,         32'h0012_3400, 1'b0},
            '{OP_LW,  32'd1021,      32'h0,         32'h0000_0000, 1'b1},
            '{OP_LW,  32'd1020,      32'h0,         32'h0000_0000, 1'b0},
            '{OP_SB,  32'd1023,      32'h0000_00A5, 32'h0000_0000, 1'b0},
            '{OP_LBU, 32'd1023,      32'h0,         32'h0000_00A5, 1'b0},
            '{OP_LB,  32'd1023,      32'h0,         32'hFFFF_FFA5, 1'b0},
            '{OP_SH,  32'd1023,      32'h0000_5555, 32'h0000_0000, 1'b1},
            '{OP_LB,  32'hFFFF_FFFF, 32'h0,         32'h0000_0000, 1'b1},
            '{OP_SH,  32'h0000_0050, 32'hFFFF_8001, 32'h0000_0000, 1'b0},
            '{OP_LH,  32'h0000_0050, 32'h0,         32'hFFFF_8001, 1'b0},
            '{OP_LHU, 32'h0000_0050, 32'h0,         32'h0000_8001, 1'b0}
        };

        rst_n = 1'b0; ram_clear = 1'b1;
        req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("rst_rsp_rdata", rsp_rdata,          32'd0);
        check("rst_mem_we",    {31'd0, mem_we},    32'd0);
        check("rst_mem_re",    {31'd0, mem_re},    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; ram_clear = 1'b0;

        for (int v = 0; v < vecs.size(); v++) begin
            run_req(vecs[v].op, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata, vecs[v].exp_err, 0);
            if (v == 0) begin
                check("ram_0x10", {24'd0, ram[10'h10]}, 32'hEF);
                check("ram_0x11", {24'd0, ram[10'h11]}, 32'hBE);
                check("ram_0x12", {24'd0, ram[10'h12]}, 32'hAD);
                check("ram_0x13", {24'd0, ram[10'h13]}, 32'hDE);
            end
        end

        // Stalled response: stray request during the stall must not reach the RAM.
        run_req(OP_LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
        check("stray_ram_0x30", {24'd0, ram[10'h30]}, 32'h00);
        run_req(OP_LBU, 32'h30, 32'h0, 32'h0, 1'b0, 0);

        // Reset in the cycle after byte 1 of a SW is issued.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h40; req_wdata = 32'h1122_3344;
        @(negedge clk);
        check("rstmid_ready_before", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
        check("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rstmid_mem_we",    {31'd0, mem_we},    32'd0);
        check("rstmid_ram_0x40",  {24'd0, ram[10'h40]}, 32'h44);
        check("rstmid_ram_0x41",  {24'd0, ram[10'h41]}, 32'h33);
        check("rstmid_ram_0x42",  {24'd0, ram[10'h42]}, 32'h00);
        check("rstmid_ram_0x43",  {24'd0, ram[10'h43]}, 32'h00);
        $display("txn op=OP_SW addr=0x00000040 aborted by reset after byte 1");
        run_req(OP_LW, 32'h40, 32'h0, 32'h0000_3344, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
